// File: rtl/lzw_decompress_core.sv
// LZW decoder: rebuilds the dictionary from the code stream and emits each string in order through a LIFO.
// Optional macro LZW_CLEAR_CODE_EN reserves code 2^DATA_W as CLEAR, so allocation starts one code later.
module lzw_decompress_core #(
    parameter int CODE_W  = 14,
    parameter int DATA_W  = 8,
    parameter int MAX_STR = 32
) (
    input  logic              I_sys_clk,
    input  logic              I_sys_rst_n,
    input  logic              I_state_clr,
    input  logic [CODE_W-1:0] I_code,
    input  logic              I_code_valid,
    output logic              O_code_ready,
    output logic [DATA_W-1:0] O_data,
    output logic              O_data_valid,
    input  logic              I_data_ready,
    output logic              O_busy,
    output logic              O_dict_full,
    output logic              O_err_code,
    output logic              O_err_ovf,
    output logic [31:0]       O_byte_cnt
);

    localparam int DICT_SIZE = 1 << CODE_W;
    localparam int SP_W      = $clog2(MAX_STR + 1);
    localparam int IDX_W     = $clog2(MAX_STR);
    localparam logic [CODE_W:0] LIT_LIMIT = {{(CODE_W-DATA_W){1'b0}}, 1'b1, {DATA_W{1'b0}}};
`ifdef LZW_CLEAR_CODE_EN
    localparam logic [CODE_W:0] FIRST_FREE = LIT_LIMIT + {{CODE_W{1'b0}}, 1'b1};
`else
    localparam logic [CODE_W:0] FIRST_FREE = LIT_LIMIT;
`endif

    typedef enum logic [1:0] {IDLE, WALK, EMIT} state_t;

    state_t                     state;
    logic [CODE_W-1:0]          in_code;
    logic [CODE_W-1:0]          cur_code;
    logic                       walk_phase;
    logic                       kwk_pending;
    logic [CODE_W:0]            next_code;
    logic [CODE_W-1:0]          prev_code;
    logic [DATA_W-1:0]          prev_first;
    logic                       prev_valid;
    logic [SP_W-1:0]            sp;
    logic [DATA_W-1:0]          lifo [MAX_STR];
    logic [CODE_W+DATA_W-1:0]   dict_mem [DICT_SIZE];
    logic [CODE_W+DATA_W-1:0]   rd_data;

    logic [DATA_W-1:0]          data_q;
    logic                       data_valid_q;
    logic                       code_ready_q;
    logic                       busy_q;
    logic                       err_code_q;
    logic                       err_ovf_q;
    logic [31:0]                byte_cnt_q;

    logic [CODE_W:0]            code_ext;
    logic                       accept;
    logic                       code_illegal;
    logic                       is_clear;
    logic                       dict_full;
    logic                       cur_is_lit;
    logic                       rd_en;
    logic                       push_en;
    logic [DATA_W-1:0]          push_char;
    logic                       lifo_full;
    logic                       walk_done;
    logic                       dict_we;
    logic [SP_W-1:0]            sp_dec;

    assign code_ext     = {1'b0, I_code};
    assign accept       = (state == IDLE) && I_code_valid && code_ready_q;
    assign code_illegal = (code_ext > next_code) || ((code_ext == next_code) && !prev_valid);
    assign dict_full    = next_code[CODE_W];
    assign cur_is_lit   = ({1'b0, cur_code} < LIT_LIMIT);
`ifdef LZW_CLEAR_CODE_EN
    assign is_clear     = (code_ext == LIT_LIMIT);
`else
    assign is_clear     = 1'b0;
`endif

    // Non-literal links take an address cycle then a capture cycle; a pending KwKwK link pushes prev_first instead of RAM data.
    assign rd_en     = (state == WALK) && !walk_phase && !cur_is_lit;
    assign push_en   = (state == WALK) && (cur_is_lit || walk_phase);
    assign push_char = cur_is_lit  ? cur_code[DATA_W-1:0] :
                       kwk_pending ? prev_first : rd_data[DATA_W-1:0];
    assign lifo_full = (sp == SP_W'(MAX_STR));
    assign walk_done = push_en && cur_is_lit && !lifo_full;
    assign dict_we   = walk_done && prev_valid && !dict_full;
    assign sp_dec    = sp - SP_W'(1);

    always_ff @(posedge I_sys_clk) begin
        if (dict_we) begin
            dict_mem[next_code[CODE_W-1:0]] <= {prev_code, cur_code[DATA_W-1:0]};
        end
        if (rd_en) begin
            rd_data <= dict_mem[cur_code];
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (push_en && !lifo_full) begin
            lifo[sp[IDX_W-1:0]] <= push_char;
        end
    end

    always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
        if (!I_sys_rst_n) begin
            state        <= IDLE;
            in_code      <= '0;
            cur_code     <= '0;
            walk_phase   <= 1'b0;
            kwk_pending  <= 1'b0;
            next_code    <= FIRST_FREE;
            prev_code    <= '0;
            prev_first   <= '0;
            prev_valid   <= 1'b0;
            sp           <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            code_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            err_code_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            byte_cnt_q   <= '0;
        end else begin
            err_code_q <= 1'b0;
            case (state)
                IDLE: begin
                    code_ready_q <= 1'b1;
                    if (accept) begin
                        if (is_clear) begin
                            next_code  <= FIRST_FREE;
                            prev_valid <= 1'b0;
                        end else if (code_illegal) begin
                            err_code_q <= 1'b1;
                        end else begin
                            in_code      <= I_code;
                            cur_code     <= I_code;
                            kwk_pending  <= (code_ext == next_code);
                            walk_phase   <= 1'b0;
                            state        <= WALK;
                            code_ready_q <= 1'b0;
                            busy_q       <= 1'b1;
                        end
                    end
                end
                WALK: begin
                    if (push_en) begin
                        if (lifo_full) begin
                            // Overlong string: drop it whole and leave dictionary and history untouched.
                            err_ovf_q    <= 1'b1;
                            sp           <= '0;
                            state        <= IDLE;
                            busy_q       <= 1'b0;
                            code_ready_q <= 1'b1;
                        end else begin
                            sp <= sp + SP_W'(1);
                            if (cur_is_lit) begin
                                state      <= EMIT;
                                prev_code  <= in_code;
                                prev_first <= cur_code[DATA_W-1:0];
                                prev_valid <= 1'b1;
                                if (dict_we) begin
                                    next_code <= next_code + {{CODE_W{1'b0}}, 1'b1};
                                end
                            end else begin
                                cur_code    <= kwk_pending ? prev_code : rd_data[CODE_W+DATA_W-1:DATA_W];
                                kwk_pending <= 1'b0;
                                walk_phase  <= 1'b0;
                            end
                        end
                    end else begin
                        walk_phase <= 1'b1;
                    end
                end
                EMIT: begin
                    if (data_valid_q && I_data_ready) begin
                        byte_cnt_q <= byte_cnt_q + 32'd1;
                        if (sp == '0) begin
                            data_valid_q <= 1'b0;
                            state        <= IDLE;
                            busy_q       <= 1'b0;
                            code_ready_q <= 1'b1;
                        end else begin
                            data_q <= lifo[sp_dec[IDX_W-1:0]];
                            sp     <= sp_dec;
                        end
                    end else if (!data_valid_q) begin
                        data_q       <= lifo[sp_dec[IDX_W-1:0]];
                        sp           <= sp_dec;
                        data_valid_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (I_state_clr) begin
                err_ovf_q  <= 1'b0;
                byte_cnt_q <= '0;
            end
        end
    end

    assign O_code_ready = code_ready_q;
    assign O_data       = data_q;
    assign O_data_valid = data_valid_q;
    assign O_busy       = busy_q;
    assign O_dict_full  = dict_full;
    assign O_err_code   = err_code_q;
    assign O_err_ovf    = err_ovf_q;
    assign O_byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_lzw_decompress_core.sv
// Bench for lzw_decompress_core: fixed vector table, hand-written corner sequences and a random
// stream checked against a string-level LZW reference model.
module tb_lzw_decompress_core;

    localparam int CODE_W  = 9;
    localparam int DATA_W  = 8;
    localparam int MAX_STR = 4;
    localparam int DICT    = 1 << CODE_W;

    logic              I_sys_clk;
    logic              I_sys_rst_n;
    logic              I_state_clr;
    logic [CODE_W-1:0] I_code;
    logic              I_code_valid;
    logic              O_code_ready;
    logic [DATA_W-1:0] O_data;
    logic              O_data_valid;
    logic              I_data_ready;
    logic              O_busy;
    logic              O_dict_full;
    logic              O_err_code;
    logic              O_err_ovf;
    logic [31:0]       O_byte_cnt;

    lzw_decompress_core #(.CODE_W(CODE_W), .DATA_W(DATA_W), .MAX_STR(MAX_STR)) dut (
        .I_sys_clk    (I_sys_clk),
        .I_sys_rst_n  (I_sys_rst_n),
        .I_state_clr  (I_state_clr),
        .I_code       (I_code),
        .I_code_valid (I_code_valid),
        .O_code_ready (O_code_ready),
        .O_data       (O_data),
        .O_data_valid (O_data_valid),
        .I_data_ready (I_data_ready),
        .O_busy       (O_busy),
        .O_dict_full  (O_dict_full),
        .O_err_code   (O_err_code),
        .O_err_ovf    (O_err_ovf),
        .O_byte_cnt   (O_byte_cnt)
    );

    initial I_sys_clk = 1'b0;
    always #5 I_sys_clk = ~I_sys_clk;

    typedef logic [7:0] str_t[$];
    typedef struct {
        int          code;
        int          len;
        logic [31:0] chars;
        bit          err;
    } vec_t;

    vec_t        vecs[5];
    int          cmp_cnt = 0;
    int          fail_cnt = 0;
    int          err_seen;
    logic [7:0]  got_q[$];
    bit          stall_prev = 0;
    logic [7:0]  stall_data;
    int          rdy_mode = 0;
    bit          manual_ready = 0;

    // String-level reference: each dictionary entry holds its whole decoded string.
    str_t        m_dict[DICT];
    str_t        m_prev;
    str_t        exp_q;
    int          m_next;
    bit          m_pv;
    bit          m_ill;
    bit          m_ovf;
    logic [31:0] m_cnt;

    task automatic check_output(input string name, input longint act, input longint exp);
        cmp_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_next = 256;
        m_pv   = 0;
        m_prev.delete();
        m_ovf  = 0;
        m_cnt  = '0;
    endtask

    task automatic model_step(input int code);
        logic [7:0] c;
        exp_q.delete();
        m_ill = 0;
        if (code > m_next || (code == m_next && !m_pv)) begin
            m_ill = 1;
            return;
        end
        if (code < 256) begin
            c = code[7:0];
            exp_q.push_back(c);
        end else if (code == m_next) begin
            exp_q = m_prev;
            exp_q.push_back(m_prev[0]);
        end else begin
            exp_q = m_dict[code];
        end
        if (exp_q.size() > MAX_STR) begin
            m_ovf = 1;
            exp_q.delete();
            return;
        end
        if (m_pv && m_next < DICT) begin
            m_dict[m_next] = m_prev;
            m_dict[m_next].push_back(exp_q[0]);
            m_next++;
        end
        m_prev = exp_q;
        m_pv   = 1;
        m_cnt  = m_cnt + 32'(exp_q.size());
    endtask

    // Ready pattern is applied 2 time units after each rising edge so manual changes at +1 are picked up.
    initial begin
        I_data_ready = 1'b1;
        forever begin
            @(posedge I_sys_clk);
            #2;
            case (rdy_mode)
                0:       I_data_ready = 1'b1;
                1:       I_data_ready = ~I_data_ready;
                2:       I_data_ready = 1'($urandom_range(0, 1));
                default: I_data_ready = manual_ready;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge I_sys_clk);
            if (I_sys_rst_n) begin
                if (O_err_code) err_seen++;
                if (stall_prev) begin
                    check_output("hold_valid", O_data_valid, 1);
                    check_output("hold_data", O_data, stall_data);
                end
                if (O_data_valid && I_data_ready) got_q.push_back(O_data);
                stall_prev = O_data_valid && !I_data_ready;
                stall_data = O_data;
            end else begin
                stall_prev = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        I_code_valid = 0;
        I_state_clr  = 0;
        @(posedge I_sys_clk);
        #3 I_sys_rst_n = 0;
        #1;
        check_output("rst_data_valid", O_data_valid, 0);
        check_output("rst_code_ready", O_code_ready, 0);
        check_output("rst_busy", O_busy, 0);
        check_output("rst_err_ovf", O_err_ovf, 0);
        check_output("rst_byte_cnt", O_byte_cnt, 0);
        check_output("rst_dict_full", O_dict_full, 0);
        repeat (2) @(posedge I_sys_clk);
        #3 I_sys_rst_n = 1;
        model_reset();
        @(posedge I_sys_clk);
        #1;
        check_output("idle_code_ready", O_code_ready, 1);
    endtask

    task automatic start_code(input int code);
        bit ok;
        ok = 0;
        @(posedge I_sys_clk);
        #1;
        I_code       = code[CODE_W-1:0];
        I_code_valid = 1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge I_sys_clk);
            ok = O_code_ready;
        end
        if (!ok) check_output("accept_timeout", O_code_ready, 1);
        @(posedge I_sys_clk);
        #1;
        I_code_valid = 0;
    endtask

    task automatic wait_idle(output int lat);
        bit done;
        done = 0;
        lat  = 0;
        for (int c = 1; c <= 400 && !done; c++) begin
            @(posedge I_sys_clk);
            #1;
            if (lat == 0 && O_data_valid) lat = c;
            if (O_code_ready && !O_busy) done = 1;
        end
        if (!done) check_output("idle_timeout", O_busy, 0);
    endtask

    task automatic state_clr_pulse();
        @(posedge I_sys_clk);
        #1 I_state_clr = 1;
        @(posedge I_sys_clk);
        #1 I_state_clr = 0;
        m_ovf = 0;
        m_cnt = '0;
    endtask

    task automatic apply_stimulus(input int code);
        int lat;
        got_q.delete();
        err_seen = 0;
        model_step(code);
        start_code(code);
        wait_idle(lat);
        check_output($sformatf("err_code_pulse(code %0d)", code), err_seen, m_ill ? 1 : 0);
        check_output($sformatf("out_len(code %0d)", code), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_output($sformatf("out_char%0d(code %0d)", i, code), got_q[i], exp_q[i]);
        check_output("err_ovf", O_err_ovf, m_ovf);
        check_output("byte_cnt", O_byte_cnt, m_cnt);
        check_output("dict_full", O_dict_full, (m_next == DICT) ? 1 : 0);
        if (exp_q.size() > 0) check_output("latency", lat, 2 * exp_q.size());
    endtask

    task automatic run_table(input int mode);
        int          lat;
        logic [31:0] ch;
        do_reset();
        rdy_mode = mode;
        for (int i = 0; i < 5; i++) begin
            got_q.delete();
            err_seen = 0;
            model_step(vecs[i].code);
            start_code(vecs[i].code);
            wait_idle(lat);
            ch = vecs[i].chars;
            check_output($sformatf("tbl%0d_err", i), err_seen, vecs[i].err);
            check_output($sformatf("tbl%0d_len", i), got_q.size(), vecs[i].len);
            for (int j = 0; j < vecs[i].len && j < got_q.size(); j++)
                check_output($sformatf("tbl%0d_char%0d", i, j), got_q[j], ch[8*j +: 8]);
            if (!vecs[i].err) check_output($sformatf("tbl%0d_latency", i), lat, 2 * vecs[i].len);
        end
        check_output("tbl_byte_cnt", O_byte_cnt, 7);
        rdy_mode = 0;
    endtask

    initial begin
        int  lat;
        bit  ok;
        int  code;
        int  r;

        vecs[0] = '{300, 0, 32'h0000_0000, 1'b1};
        vecs[1] = '{97,  1, 32'h0000_0061, 1'b0};
        vecs[2] = '{98,  1, 32'h0000_0062, 1'b0};
        vecs[3] = '{256, 2, 32'h0000_6261, 1'b0};
        vecs[4] = '{258, 3, 32'h0061_6261, 1'b0};

        I_sys_rst_n  = 0;
        I_code       = '0;
        I_code_valid = 0;
        I_state_clr  = 0;
        model_reset();

        run_table(0);
        run_table(1);

        // Overflow: the fifth 'a' pushes into a full LIFO.
        do_reset();
        apply_stimulus(97);
        apply_stimulus(256);
        apply_stimulus(257);
        apply_stimulus(258);
        apply_stimulus(259);
        check_output("ovf_set", O_err_ovf, 1);
        apply_stimulus(98);
        apply_stimulus(260);
        state_clr_pulse();
        check_output("ovf_cleared", O_err_ovf, 0);
        check_output("cnt_cleared", O_byte_cnt, 0);

        // Clear lands on the same edge as a byte handshake.
        apply_stimulus(97);
        rdy_mode     = 3;
        manual_ready = 0;
        got_q.delete();
        err_seen = 0;
        model_step(98);
        start_code(98);
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge I_sys_clk);
            #1;
            ok = O_data_valid;
        end
        check_output("clr_wait_valid", O_data_valid, 1);
        manual_ready = 1;
        I_state_clr  = 1;
        @(posedge I_sys_clk);
        #1 I_state_clr = 0;
        m_cnt = '0;
        wait_idle(lat);
        check_output("clr_wins_cnt", O_byte_cnt, 0);
        check_output("clr_wins_bytes", got_q.size(), 1);
        rdy_mode = 0;

        // Reset while a 4-character string is stalled in EMIT.
        do_reset();
        apply_stimulus(97);
        apply_stimulus(256);
        apply_stimulus(257);
        rdy_mode     = 3;
        manual_ready = 0;
        start_code(258);
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge I_sys_clk);
            #1;
            ok = O_data_valid;
        end
        check_output("mid_valid_before_rst", O_data_valid, 1);
        repeat (2) @(posedge I_sys_clk);
        #3 I_sys_rst_n = 0;
        #1;
        check_output("mid_rst_valid", O_data_valid, 0);
        check_output("mid_rst_busy", O_busy, 0);
        @(posedge I_sys_clk);
        #3 I_sys_rst_n = 1;
        model_reset();
        rdy_mode = 0;
        apply_stimulus(98);
        apply_stimulus(97);
        apply_stimulus(256);

        // Dictionary fill with literals, then decoding from the frozen table.
        do_reset();
        for (int i = 0; i < 257; i++) apply_stimulus(97 + $urandom_range(0, 3));
        check_output("dict_full_at_limit", O_dict_full, 1);
        apply_stimulus(300);
        apply_stimulus(511);
        apply_stimulus(98);
        apply_stimulus(511);

        // Random stream against the reference model with random backpressure.
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40 || m_next >= DICT) code = 97 + $urandom_range(0, 2);
            else if (r < 70 && m_next > 256) code = $urandom_range(256, m_next - 1);
            else if (r < 88) code = m_next;
            else if (m_next < DICT - 1) code = $urandom_range(m_next + 1, DICT - 1);
            else code = 98;
            apply_stimulus(code);
            if (i % 60 == 59) begin
                state_clr_pulse();
                check_output("rand_clr_cnt", O_byte_cnt, 0);
            end
        end
        rdy_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
